// File: rtl/mtsp_id_pkg.sv
// mtsp_id_pkg: shared constants and types for the Meitner shader-core
// instruction-decode stage.
//   DWORD_W     width of one source-vector component
//   NOP_UINST   all-ones unit-instruction pattern. Slice it to the bundle width.
//   id_state_e  occupancy state of the stage (main / skid registers)
//   swz_sel_w() bits needed to select one of LANES components
package mtsp_id_pkg;

  localparam int DWORD_W     = 32;
  localparam int UINST_MAX_W = 1024;

  // All-ones is the NOP encoding for every unit instruction slot.
  localparam logic [UINST_MAX_W-1:0] NOP_UINST = '1;

  // Encoding mirrors {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ID_EMPTY = 2'b00,
    ID_HALF  = 2'b01,
    ID_FULL  = 2'b11
  } id_state_e;

  function automatic int swz_sel_w(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/mtsp_id_swizzle.sv
// mtsp_id_swizzle: per-lane component select for one source vector.
//   src_i  LANES x DWORD source vector, lane 0 in LSBs
//   sel_i  LANES x SEL_W selects, lane 0 in LSBs
//   src_o  output lane k = src_i lane sel_i[k] when EN=1, else src_i unchanged
module mtsp_id_swizzle
  import mtsp_id_pkg::*;
#(
  parameter int  LANES = 4,
  parameter bit  EN    = 1'b1,
  localparam int SEL_W = swz_sel_w(LANES)
) (
  input  logic [LANES*DWORD_W-1:0] src_i,
  input  logic [LANES*SEL_W-1:0]   sel_i,
  output logic [LANES*DWORD_W-1:0] src_o
);

  logic [LANES*DWORD_W-1:0] muxed;
  logic [SEL_W-1:0]         sel;

  always_comb begin
    muxed = '0;
    sel   = '0;
    for (int k = 0; k < LANES; k++) begin
      sel = sel_i[k*SEL_W +: SEL_W];
      for (int j = 0; j < LANES; j++) begin
        if (sel == SEL_W'(j)) begin
          muxed[k*DWORD_W +: DWORD_W] = src_i[j*DWORD_W +: DWORD_W];
        end
      end
    end
  end

  // A disabled source ignores its selects entirely.
  assign src_o = EN ? muxed : src_i;

endmodule

// File: rtl/mtsp_id_stage.sv
// mtsp_id_stage: parametrised decode pipeline stage (PC, unit instructions,
// swizzled source vectors) with a valid/ready handshake and a 2-entry skid.
//   CLK, nRST            clock, asynchronous active-low reset
//   FLUSH                synchronous discard of all held / presented bundles
//   IN_VALID/IN_READY    upstream handshake
//   IN_PC/IN_UINST       bundle PC and unit instructions
//   IN_SRC/IN_SWZ        source vectors (source 0 in MSBs) and per-lane selects
//   OUT_VALID/OUT_READY  downstream handshake
//   OUT_PC/OUT_UINST     registered PC and instructions (NOP while !OUT_VALID)
//   OUT_SRC              registered, swizzled sources
//   STALL_CNT            only with MTSP_ID_STAGE_PERF_EN: saturating count
//                        of cycles with OUT_VALID=1 and OUT_READY=0
//
// Handshake: a bundle moves on a side exactly in a cycle where that side's
// valid and ready are both high at the rising edge. IN_READY comes straight
// from the state flop, so it never depends on OUT_READY in the same cycle.
module mtsp_id_stage
  import mtsp_id_pkg::*;
#(
  parameter int              PC_W        = 30,
  parameter int              UINST_W     = 32,
  parameter int              NUINST      = 4,
  parameter int              NSRC        = 2,
  parameter int              LANES       = 4,
  parameter logic [NSRC-1:0] SWZ_EN_MASK = 2'b10,
  localparam int             SEL_W       = swz_sel_w(LANES),
  localparam int             SRC_W       = LANES * DWORD_W,
  localparam int             SRC_TOT_W   = NSRC * SRC_W,
  localparam int             UINST_TOT_W = NUINST * UINST_W,
  localparam int             SWZ_SRC_W   = LANES * SEL_W,
  localparam int             SWZ_TOT_W   = NSRC * SWZ_SRC_W
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [PC_W-1:0]        IN_PC,
  input  logic [UINST_TOT_W-1:0] IN_UINST,
  input  logic [SRC_TOT_W-1:0]   IN_SRC,
  input  logic [SWZ_TOT_W-1:0]   IN_SWZ,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [PC_W-1:0]        OUT_PC,
  output logic [UINST_TOT_W-1:0] OUT_UINST,
  output logic [SRC_TOT_W-1:0]   OUT_SRC
`ifdef MTSP_ID_STAGE_PERF_EN
  ,
  output logic [31:0]            STALL_CNT
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic [UINST_TOT_W-1:0] uinst;
    logic [SRC_TOT_W-1:0]   src;
  } id_bundle_t;

  localparam id_bundle_t RESET_BUNDLE = '{
    pc:    '0,
    uinst: NOP_UINST[UINST_TOT_W-1:0],
    src:   '0
  };

  // ---------------------------------------------------------------------
  // Input-side swizzle, ahead of the storage registers
  // ---------------------------------------------------------------------
  logic [SRC_TOT_W-1:0] swz_src;

  for (genvar s = 0; s < NSRC; s++) begin : g_swz
    mtsp_id_swizzle #(
      .LANES (LANES),
      .EN    (SWZ_EN_MASK[s])
    ) u_swz (
      .src_i (IN_SRC[(NSRC-1-s)*SRC_W +: SRC_W]),
      .sel_i (IN_SWZ[(NSRC-1-s)*SWZ_SRC_W +: SWZ_SRC_W]),
      .src_o (swz_src[(NSRC-1-s)*SRC_W +: SRC_W])
    );
  end

  // ---------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------
  id_state_e state_q, state_d;
  logic      in_ready;
  logic      out_valid;
  logic      in_fire;
  logic      out_fire;

  // Output process: handshake outputs derive from the registered state only.
  always_comb begin
    in_ready  = (state_q != ID_FULL);
    out_valid = (state_q != ID_EMPTY);
  end

  // A bundle presented during FLUSH is dropped even if it would be accepted.
  assign in_fire  = IN_VALID & in_ready & ~FLUSH;
  assign out_fire = out_valid & OUT_READY;

  // Next-state process
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ID_EMPTY;
    end else begin
      unique case (state_q)
        ID_EMPTY: if (in_fire) state_d = ID_HALF;
        ID_HALF: begin
          if (in_fire && !out_fire)      state_d = ID_FULL;
          else if (!in_fire && out_fire) state_d = ID_EMPTY;
        end
        ID_FULL:  if (out_fire) state_d = ID_HALF;
        default:  state_d = ID_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ID_EMPTY;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Main and skid storage
  // ---------------------------------------------------------------------
  id_bundle_t in_b;
  id_bundle_t main_q, main_d;
  id_bundle_t skid_q, skid_d;

  always_comb begin
    in_b   = '{pc: IN_PC, uinst: IN_UINST, src: swz_src};
    main_d = main_q;
    skid_d = skid_q;
    // On FLUSH the registers hold: OUT_PC/OUT_SRC stay put, and OUT_UINST
    // reads NOP because the stage is empty.
    if (!FLUSH) begin
      unique case (state_q)
        ID_EMPTY: if (in_fire) main_d = in_b;
        ID_HALF: begin
          if (in_fire && out_fire) main_d = in_b;
          else if (in_fire)        skid_d = in_b;
        end
        // The skid entry is older than anything upstream, so it refills main.
        ID_FULL:  if (out_fire) main_d = skid_q;
        default:  main_d = main_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_q <= RESET_BUNDLE;
      skid_q <= RESET_BUNDLE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid;
  assign OUT_PC    = main_q.pc;
  assign OUT_SRC   = main_q.src;
  // Consumers that ignore OUT_VALID see a NOP bubble whenever the stage is empty.
  assign OUT_UINST = out_valid ? main_q.uinst : NOP_UINST[UINST_TOT_W-1:0];

  // ---------------------------------------------------------------------
  // Optional stall counter (survives FLUSH, cleared only by nRST)
  // ---------------------------------------------------------------------
`ifdef MTSP_ID_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !OUT_READY && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mtsp_id_stage.sv
module tb_mtsp_id_stage;

  localparam int PC_W  = 30;
  localparam int UI_W  = 128;
  localparam int SRC_W = 256;
  localparam int SWZ_W = 16;
  // src1 lane0<-3, lane1<-2, lane2<-1, lane3<-0 : {2'd0,2'd1,2'd2,2'd3}
  localparam logic [7:0] SWZ_REV = 8'h1B;

  // ---------------- clock / reset ----------------
  logic              CLK = 1'b0;
  logic              nRST;
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [PC_W-1:0]   IN_PC;
  logic [UI_W-1:0]   IN_UINST;
  logic [SRC_W-1:0]  IN_SRC;
  logic [SWZ_W-1:0]  IN_SWZ;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [PC_W-1:0]   OUT_PC;
  logic [UI_W-1:0]   OUT_UINST;
  logic [SRC_W-1:0]  OUT_SRC;
`ifdef MTSP_ID_STAGE_PERF_EN
  logic [31:0]       STALL_CNT;
`endif

  always #5 CLK = ~CLK;

  mtsp_id_stage dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_PC     (IN_PC),
    .IN_UINST  (IN_UINST),
    .IN_SRC    (IN_SRC),
    .IN_SWZ    (IN_SWZ),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_PC    (OUT_PC),
    .OUT_UINST (OUT_UINST),
    .OUT_SRC   (OUT_SRC)
`ifdef MTSP_ID_STAGE_PERF_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int                n_vec = 0;
  int                n_err = 0;
  logic [PC_W-1:0]   exp_q[$];
  logic [UI_W-1:0]   ones_ui;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // ---------------- bundle contents ----------------
  function automatic logic [31:0] word(input logic [7:0] t, input logic [PC_W-1:0] pc);
    return {t, 16'h0000, pc[7:0]};
  endfunction

  function automatic logic [UI_W-1:0] uinst_of(input logic [PC_W-1:0] pc);
    return {2'b00, pc, 2'b01, pc, 2'b10, pc, 2'b00, ~pc};
  endfunction

  function automatic logic [127:0] src0_of(input logic [PC_W-1:0] pc);
    return {word(8'h13, pc), word(8'h12, pc), word(8'h11, pc), word(8'h10, pc)};
  endfunction

  // Source 1 presented as lanes {A,B,C,D} (A = lane 3).
  function automatic logic [SRC_W-1:0] in_src(input logic [PC_W-1:0] pc);
    return {src0_of(pc), word(8'hAA, pc), word(8'hBB, pc), word(8'hCC, pc), word(8'hDD, pc)};
  endfunction

  // Expected after reverse swizzle on source 1 only: {D,C,B,A}.
  function automatic logic [SRC_W-1:0] exp_src(input logic [PC_W-1:0] pc);
    return {src0_of(pc), word(8'hDD, pc), word(8'hCC, pc), word(8'hBB, pc), word(8'hAA, pc)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [SWZ_W-1:0] swz);
    IN_VALID = v;
    IN_PC    = pc;
    IN_UINST = uinst_of(pc);
    IN_SRC   = in_src(pc);
    IN_SWZ   = swz;
  endtask

  function automatic logic [SWZ_W-1:0] rnd_swz();
    logic [7:0] s0;
    s0 = 8'($urandom_range(0, 255));
    return {s0, SWZ_REV};
  endfunction

  // Score the transfers about to happen on the next rising edge, then move
  // to the following falling edge.
  task automatic advance();
    logic [PC_W-1:0] pc;
    if (OUT_VALID && OUT_READY) begin
      check("sb_has_entry", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        pc = exp_q.pop_front();
        check("sb_pc", 256'(OUT_PC), 256'(pc));
        check("sb_uinst", 256'(OUT_UINST), 256'(uinst_of(pc)));
        check("sb_src", OUT_SRC, exp_src(pc));
      end
    end
    if (FLUSH) exp_q.delete();
    else if (IN_VALID && IN_READY) exp_q.push_back(IN_PC);
    @(negedge CLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ones_ui   = '1;
    nRST      = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_W'($urandom_range(0, 1000)), 16'($urandom_range(0, 65535)));
      OUT_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    check("rst_valid", 256'(OUT_VALID), 256'(0));
    check("rst_uinst", 256'(OUT_UINST), 256'(ones_ui));
    check("rst_pc", 256'(OUT_PC), 256'(0));
    check("rst_src", OUT_SRC, 256'(0));
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    nRST      = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", 256'(IN_READY), 256'(1));
    check("rst_valid_rel", 256'(OUT_VALID), 256'(0));

    // Pass-through, back-to-back, reversed swizzle on source 1
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, PC_W'(32'h10 + i), {SWZ_REV, SWZ_REV});
      advance();
      check("pt_valid", 256'(OUT_VALID), 256'(1));
      check("pt_pc", 256'(OUT_PC), 256'(32'h10 + i));
    end
    check("pt_src_rev", OUT_SRC, exp_src(PC_W'(32'h17)));
    IN_VALID = 1'b0;
    advance();
    check("pt_idle_valid", 256'(OUT_VALID), 256'(0));
    check("pt_idle_uinst", 256'(OUT_UINST), 256'(ones_ui));
    check("pt_idle_pc", 256'(OUT_PC), 256'(32'h17));

    // Backpressure into the skid register
    OUT_READY = 1'b0;
    drive(1'b1, PC_W'(32'h20), rnd_swz());
    advance();
    check("bp_valid1", 256'(OUT_VALID), 256'(1));
    check("bp_pc1", 256'(OUT_PC), 256'(32'h20));
    check("bp_rdy1", 256'(IN_READY), 256'(1));
    drive(1'b1, PC_W'(32'h21), rnd_swz());
    advance();
    check("bp_rdy2", 256'(IN_READY), 256'(0));
    check("bp_pc2", 256'(OUT_PC), 256'(32'h20));
    drive(1'b1, PC_W'(32'h22), rnd_swz());
    advance();
    check("bp_rdy3", 256'(IN_READY), 256'(0));
    OUT_READY = 1'b1;
    advance();
    check("bp_pc4", 256'(OUT_PC), 256'(32'h21));
    check("bp_rdy4", 256'(IN_READY), 256'(1));
    advance();
    check("bp_pc5", 256'(OUT_PC), 256'(32'h22));
    IN_VALID = 1'b0;
    advance();
    check("bp_valid_end", 256'(OUT_VALID), 256'(0));
    check("bp_drain", 256'(exp_q.size()), 256'(0));

    // Flush while FULL with an input presented
    OUT_READY = 1'b0;
    drive(1'b1, PC_W'(32'h30), rnd_swz());
    advance();
    drive(1'b1, PC_W'(32'h31), rnd_swz());
    advance();
    check("fl_full", 256'(IN_READY), 256'(0));
    FLUSH = 1'b1;
    drive(1'b1, PC_W'(32'h32), rnd_swz());
    advance();
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check("fl_valid", 256'(OUT_VALID), 256'(0));
    check("fl_uinst", 256'(OUT_UINST), 256'(ones_ui));
    check("fl_rdy", 256'(IN_READY), 256'(1));
    check("fl_pc_held", 256'(OUT_PC), 256'(32'h30));
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      check("fl_no_out", 256'(OUT_VALID), 256'(0));
    end

    // Flush together with an output transfer in HALF, input dropped
    drive(1'b1, PC_W'(32'h40), rnd_swz());
    advance();
    check("flo_pc", 256'(OUT_PC), 256'(32'h40));
    FLUSH = 1'b1;
    drive(1'b1, PC_W'(32'h41), rnd_swz());
    advance();
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check("flo_valid", 256'(OUT_VALID), 256'(0));
    check("flo_pc_held", 256'(OUT_PC), 256'(32'h40));
    advance();
    check("flo_still_empty", 256'(OUT_VALID), 256'(0));
    drive(1'b1, PC_W'(32'h42), rnd_swz());
    advance();
    check("flo_resume", 256'(OUT_PC), 256'(32'h42));
    IN_VALID = 1'b0;
    advance();
    check("flo_drain", 256'(exp_q.size()), 256'(0));

    // Asynchronous reset while FULL
    OUT_READY = 1'b0;
    drive(1'b1, PC_W'(32'h50), rnd_swz());
    advance();
    drive(1'b1, PC_W'(32'h51), rnd_swz());
    advance();
    check("ar_full", 256'(IN_READY), 256'(0));
    IN_VALID = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("ar_valid", 256'(OUT_VALID), 256'(0));
    check("ar_pc", 256'(OUT_PC), 256'(0));
    check("ar_uinst", 256'(OUT_UINST), 256'(ones_ui));
    check("ar_src", OUT_SRC, 256'(0));
    check("ar_rdy", 256'(IN_READY), 256'(1));
    exp_q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("ar_post_valid", 256'(OUT_VALID), 256'(0));

`ifdef MTSP_ID_STAGE_PERF_EN
    // Stall counter: 5 stalls, FLUSH keeps it, saturation
    OUT_READY = 1'b0;
    check("pf_reset", 256'(STALL_CNT), 256'(0));
    drive(1'b1, PC_W'(32'h60), rnd_swz());
    advance();
    IN_VALID = 1'b0;
    repeat (5) advance();
    check("pf_cnt5", 256'(STALL_CNT), 256'(5));
    FLUSH     = 1'b1;
    OUT_READY = 1'b1;
    advance();
    FLUSH = 1'b0;
    check("pf_flush_keep", 256'(STALL_CNT), 256'(5));
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    OUT_READY = 1'b0;
    drive(1'b1, PC_W'(32'h61), rnd_swz());
    advance();
    IN_VALID = 1'b0;
    advance();
    check("pf_pre_sat", 256'(STALL_CNT), 256'(32'hFFFF_FFFE));
    repeat (3) advance();
    check("pf_sat", 256'(STALL_CNT), 256'(32'hFFFF_FFFF));
    OUT_READY = 1'b1;
    advance();
    check("pf_drain", 256'(exp_q.size()), 256'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
